// File: rtl/auth_pkg.sv
// auth_pkg: shared definitions for the rider-authentication command transmitter.
//   CMD_GO / CMD_STOP : command bytes sent on the serial link ('g' / 's').
//   BAUD_W            : width of the per-bit baud countdown.
//   tx_state_t        : frame sequencer states.
package auth_pkg;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;
  localparam int         BAUD_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART frame sequencer (shift register, baud/bit counters, FSM).
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   trmt     : launch request, honoured only while tx_ready is high
//   tx_data  : byte to send, captured when the START bit is entered
//   tx       : registered serial output, idle high
//   tx_done  : one-cycle pulse at the end of each stop bit
//   busy     : registered, high while a frame is in progress
//   tx_ready : high in IDLE and in the last cycle of the stop bit, i.e. the
//              cycles in which trmt starts a new frame on the next edge
module uart_tx_core
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  output logic       busy,
  output logic       tx_ready
);

  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  // IDLE also holds baud_q at zero, so the bit boundary needs the state qualifier.
  assign bit_end  = (state_q != IDLE) && (baud_q == '0);
  assign tx_ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (trmt) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && (bit_q == 3'd7)) state_d = STOP;
      STOP:  if (bit_end) state_d = trmt ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    // Every bit entry reloads the countdown, including DATA->DATA bit steps.
    if ((state_d != state_q) || ((state_q == DATA) && bit_end)) begin
      baud_d = BAUD_LOAD;
    end else if (baud_q != '0) begin
      baud_d = baud_q - 1'b1;
    end
    if ((state_q == DATA) && bit_end) begin
      bit_d   = bit_q + 3'd1;
      shift_d = shift_q >> 1;
    end
    if ((state_d == START) && (state_q != START)) begin
      shift_d = tx_data;
    end
    // TX follows the next state so the line changes on the same edge as the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && bit_end;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q <= '0;
      bit_q  <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
    shift_q <= shift_d;
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign busy    = busy_q;

endmodule

// File: rtl/auth_tx.sv
// auth_tx: command-side UART transmitter for the rider-authentication link.
// Turns one-cycle go/stop requests into 8N1 frames carrying 'g' / 's',
// with a one-deep pending slot for requests arriving during a frame.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   go   : one-cycle request to send 0x67
//   stop : one-cycle request to send 0x73 (wins over go)
//   TX   : registered serial output, idle high
//   busy : high while a frame is on TX
//   pend : high while a request waits in the pending slot
//   done : one-cycle pulse at the end of each stop bit
module auth_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic stop,
  output logic TX,
  output logic busy,
  output logic pend,
  output logic done
);

  logic       req_v;
  logic [7:0] req_b;
  logic       slot_vld_q, slot_vld_d;
  logic [7:0] slot_byte_q, slot_byte_d;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       core_busy;
  logic       consume;

  assign req_v = go | stop;
  assign req_b = stop ? CMD_STOP : CMD_GO;

  // A waiting slot always goes first; a fresh request launches directly only
  // from an idle line. A request in the last stop-bit cycle with an empty slot
  // is parked, since the line is still busy then.
  assign trmt    = slot_vld_q || (!core_busy && req_v);
  assign tx_data = slot_vld_q ? slot_byte_q : req_b;
  assign consume = tx_ready && slot_vld_q;

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_byte_d = slot_byte_q;
    if (consume) begin
      slot_vld_d  = req_v;
      slot_byte_d = req_b;
    end else if (req_v && core_busy) begin
      // A parked 's' is never downgraded to 'g'.
      if (!(slot_vld_q && (slot_byte_q == CMD_STOP) && !stop)) begin
        slot_vld_d  = 1'b1;
        slot_byte_d = req_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q  <= 1'b0;
      slot_byte_q <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_byte_q <= slot_byte_d;
    end
  end

  uart_tx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx      (TX),
    .tx_done (done),
    .busy    (core_busy),
    .tx_ready(tx_ready)
  );

  assign busy = core_busy;
  assign pend = slot_vld_q;

endmodule

// File: tb/tb_auth_tx.sv
module tb_auth_tx;
  import auth_pkg::*;

  localparam int B = 4;

  logic clk = 1'b0;
  logic rst, go, stop;
  logic TX, busy, pend, done;

  auth_tx #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .go  (go),
    .stop(stop),
    .TX  (TX),
    .busy(busy),
    .pend(pend),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a frame is a cycle offset into a 10*B-cycle window.
  bit         m_act;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_sv;
  logic [7:0] m_sb;
  bit         m_done;

  function automatic bit m_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_t / B;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  task automatic model_step(input bit g, input bit s, input bit r);
    bit         rv;
    logic [7:0] rb;
    bit         ending;
    if (r) begin
      m_act = 0; m_t = 0; m_sv = 0; m_done = 0;
      return;
    end
    rv     = g | s;
    rb     = s ? CMD_STOP : CMD_GO;
    ending = m_act && (m_t == 10*B - 1);
    m_done = ending;
    if (m_act && !ending) begin
      m_t++;
      if (rv && !(m_sv && m_sb == CMD_STOP && !s)) begin
        m_sv = 1; m_sb = rb;
      end
    end else if (m_sv) begin
      m_act = 1; m_t = 0; m_byte = m_sb;
      m_sv = rv; m_sb = rb;
    end else if (ending) begin
      m_act = 0;
      if (rv) begin m_sv = 1; m_sb = rb; end
    end else if (rv) begin
      m_act = 1; m_t = 0; m_byte = rb;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit g, input bit s, input bit r);
    go = g; stop = s; rst = r;
    @(posedge clk);
    model_step(g, s, r);
    #1;
    chk("tx",   TX,   m_tx());
    chk("busy", busy, m_act);
    chk("pend", pend, m_sv);
    chk("done", done, m_done);
    go = 0; stop = 0; rst = 0;
  endtask

  typedef struct {
    int k;
    bit tx, busy, pend, done;
  } vec_t;

  vec_t tv[15];
  int   ndone;
  bit   busy_gap;

  initial begin
    // Expected line state after edge E0+k for a lone 'go' (0x67 LSB first: 1,1,1,0,0,1,1,0).
    tv[0]  = '{0,  0, 1, 0, 0};
    tv[1]  = '{3,  0, 1, 0, 0};
    tv[2]  = '{4,  1, 1, 0, 0};
    tv[3]  = '{8,  1, 1, 0, 0};
    tv[4]  = '{15, 1, 1, 0, 0};
    tv[5]  = '{16, 0, 1, 0, 0};
    tv[6]  = '{20, 0, 1, 0, 0};
    tv[7]  = '{24, 1, 1, 0, 0};
    tv[8]  = '{31, 1, 1, 0, 0};
    tv[9]  = '{32, 0, 1, 0, 0};
    tv[10] = '{35, 0, 1, 0, 0};
    tv[11] = '{36, 1, 1, 0, 0};
    tv[12] = '{39, 1, 1, 0, 0};
    tv[13] = '{40, 1, 0, 0, 1};
    tv[14] = '{41, 1, 0, 0, 0};

    go = 0; stop = 0; rst = 1;
    m_act = 0; m_t = 0; m_sv = 0; m_done = 0; m_byte = '0; m_sb = '0;

    // Reset state
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_tx", TX, 1);
    chk("rst_busy", busy, 0);
    step(0, 0, 0);

    // Single go, table-driven
    for (int k = 0; k <= 41; k++) begin
      step(k == 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
        if (tv[i].k == k) begin
          chk("vec_tx",   TX,   tv[i].tx);
          chk("vec_busy", busy, tv[i].busy);
          chk("vec_pend", pend, tv[i].pend);
          chk("vec_done", done, tv[i].done);
        end
      end
    end
    repeat (3) step(0, 0, 0);

    // Simultaneous go+stop in IDLE: 0x73, data bit 2 is 0
    for (int k = 0; k <= 42; k++) begin
      step(k == 0, k == 0, 0);
      if (k == 1)  chk("sim_pend", pend, 0);
      if (k == 12) chk("sim_bit2", TX, 0);
    end

    // Queued: go E0, go E0+10, stop E0+20
    ndone = 0; busy_gap = 0;
    for (int k = 0; k <= 82; k++) begin
      step(k == 0 || k == 10, k == 20, 0);
      if (k < 80 && !busy) busy_gap = 1;
      if (done) ndone++;
      if (k == 21) chk("q_pend_up", pend, 1);
      if (k == 39) chk("q_pend_hold", pend, 1);
      if (k == 40) begin
        chk("q_pend_fall", pend, 0);
        chk("q_start", TX, 0);
        chk("q_done1", done, 1);
      end
      if (k == 52) chk("q_bit2", TX, 0);
      if (k == 80) chk("q_busy_end", busy, 0);
    end
    chk("q_busy_gap", busy_gap, 0);
    chk("q_ndone", ndone, 2);

    // 's' protection: stop E0+5, go E0+15
    for (int k = 0; k <= 82; k++) begin
      step(k == 0 || k == 15, k == 5, 0);
      if (k == 52) chk("prot_bit2", TX, 0);
      if (k == 56) chk("prot_bit3", TX, 0);
    end

    // Reset mid-frame with a pending request
    for (int k = 0; k <= 18; k++) begin
      step(k == 0, k == 5, k >= 17);
      if (k == 16) chk("mr_pend_before", pend, 1);
      if (k == 17) begin
        chk("mr_tx", TX, 1);
        chk("mr_busy", busy, 0);
        chk("mr_pend", pend, 0);
      end
    end
    for (int k = 0; k <= 43; k++) begin
      step(k == 1, 0, 0);
      if (k == 41) chk("mr_done", done, 1);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
           $urandom_range(0, 999) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
